// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared vending typedefs, coin-dispenser state and coin types
package vend_pkg;

    localparam int unsigned AMOUNT_W = 5;

    // Money held in nickel units (dime = 2).
    typedef logic [AMOUNT_W-1:0] nickel_units_t;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        PULSE,
        WAIT_ACK,
        GAP,
        DONE,
        FAULT
    } dispense_state_t;

    typedef enum logic {
        NICKEL,
        DIME
    } coin_t;

    // Value of one dispensed coin in nickel units.
    function automatic nickel_units_t coin_value(input coin_t c);
        return (c == DIME) ? nickel_units_t'(2) : nickel_units_t'(1);
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - payout request / hopper / status signal bundle
//   start, amount, dime_empty, hopper_ack : toward the dispenser
//   nickel_out, dime_out, busy, done, fault, remaining : from the dispenser
interface change_dispenser_if;
    import vend_pkg::*;

    logic          start;
    nickel_units_t amount;
    logic          dime_empty;
    logic          hopper_ack;
    logic          nickel_out;
    logic          dime_out;
    logic          busy;
    logic          done;
    logic          fault;
    nickel_units_t remaining;

    // The dispenser itself.
    modport slave (
        input  start, amount, dime_empty, hopper_ack,
        output nickel_out, dime_out, busy, done, fault, remaining
    );

    // The vending controller / hopper side.
    modport master (
        output start, amount, dime_empty, hopper_ack,
        input  nickel_out, dime_out, busy, done, fault, remaining
    );
endinterface

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter that parks at zero
//   clk, rst (async active-low), load, value[WIDTH] : load value on load
//   expired : count has reached zero
module cycle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Loading N-1 makes expired rise on the Nth cycle after the load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - coin change dispenser, dimes first, nickel fallback
//   clk, rst (async active-low)
//   bus.slave : start/amount request, dime_empty, hopper_ack in;
//               nickel_out/dime_out solenoids, busy, done, fault, remaining out
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 10,
    parameter int unsigned GAP_CYCLES   = 5,
    parameter int unsigned ACK_TIMEOUT  = 50
) (
    input  logic              clk,
    input  logic              rst,
    change_dispenser_if.slave bus
);

    localparam int unsigned T_MAX =
        (PULSE_CYCLES > GAP_CYCLES)
            ? ((PULSE_CYCLES > ACK_TIMEOUT) ? PULSE_CYCLES : ACK_TIMEOUT)
            : ((GAP_CYCLES   > ACK_TIMEOUT) ? GAP_CYCLES   : ACK_TIMEOUT);
    localparam int unsigned TIMER_W = $clog2(T_MAX + 1);

    dispense_state_t state;
    coin_t           coin;
    nickel_units_t   remaining_q;
    logic            ack_seen;
    logic            nickel_q;
    logic            dime_q;
    logic            busy_q;
    logic            done_q;
    logic            fault_q;

    logic               phase_load;
    logic [TIMER_W-1:0] phase_value;
    logic               phase_expired;
    logic               ack_load;
    logic               ack_expired;
    logic               ack_take;
    logic               coin_go;
    nickel_units_t      step;

    assign coin_go  = (state == SELECT) && (remaining_q != '0);
    assign ack_take = ((state == PULSE) || (state == WAIT_ACK))
                      && bus.hopper_ack && !ack_seen;
    assign step     = coin_value(coin);

    // One timer paces the pulse and then the gap; they never overlap.
    always_comb begin
        phase_load  = 1'b0;
        phase_value = TIMER_W'(PULSE_CYCLES - 1);
        if (coin_go) begin
            phase_load  = 1'b1;
        end else if ((state == WAIT_ACK) && (ack_seen || ack_take)) begin
            phase_load  = 1'b1;
            phase_value = TIMER_W'(GAP_CYCLES - 1);
        end
    end

    // The ack window runs across the pulse, so it needs its own timer.
    assign ack_load = coin_go;

    cycle_timer #(.WIDTH(TIMER_W)) u_phase_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (phase_load),
        .value   (phase_value),
        .expired (phase_expired)
    );

    cycle_timer #(.WIDTH(TIMER_W)) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (ack_load),
        .value   (TIMER_W'(ACK_TIMEOUT - 1)),
        .expired (ack_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            coin        <= NICKEL;
            remaining_q <= '0;
            ack_seen    <= 1'b0;
            nickel_q    <= 1'b0;
            dime_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Only the first ack of a coin is credited; the pulse keeps going.
            if (ack_take) begin
                ack_seen    <= 1'b1;
                remaining_q <= (remaining_q > step) ? remaining_q - step : '0;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        remaining_q <= bus.amount;
                        busy_q      <= 1'b1;
                        state       <= SELECT;
                    end
                end
                SELECT: begin
                    ack_seen <= 1'b0;
                    if (remaining_q == '0) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if ((remaining_q >= nickel_units_t'(2)) && !bus.dime_empty) begin
                        coin   <= DIME;
                        dime_q <= 1'b1;
                        state  <= PULSE;
                    end else begin
                        coin     <= NICKEL;
                        nickel_q <= 1'b1;
                        state    <= PULSE;
                    end
                end
                PULSE: begin
                    if (phase_expired) begin
                        nickel_q <= 1'b0;
                        dime_q   <= 1'b0;
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_seen || ack_take) begin
                        state <= GAP;
                    end else if (ack_expired) begin
                        busy_q  <= 1'b0;
                        fault_q <= 1'b1;
                        state   <= FAULT;
                    end
                end
                GAP: begin
                    if (phase_expired) begin
                        state <= SELECT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.nickel_out = nickel_q;
    assign bus.dime_out   = dime_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.fault      = fault_q;
    assign bus.remaining  = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed self-checking bench for change_dispenser
module tb_change_dispenser;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    change_dispenser_if dif ();

    change_dispenser #(
        .PULSE_CYCLES (4),
        .GAP_CYCLES   (2),
        .ACK_TIMEOUT  (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic request(input int amt);
        dif.amount = 5'(amt);
        dif.start  = 1'b1;
        tick();
        dif.start  = 1'b0;
    endtask

    // mode 0: ack one cycle after the pulse ends; 1: two acks inside the pulse; 2: no ack
    task automatic serve_coin(input string tag, input bit exp_dime, input int exp_rem, input int mode);
        int k;
        int w;
        bit both;
        k = 0;
        while (!(dif.nickel_out || dif.dime_out) && k < 50) begin
            tick();
            k++;
        end
        check_eq({tag, "_start"}, 32'(k < 50), 1);
        if (k >= 50) return;
        check_eq({tag, "_kind"}, 32'(dif.dime_out), 32'(exp_dime));
        w    = 0;
        both = 1'b0;
        while ((dif.nickel_out || dif.dime_out) && w < 20) begin
            if (dif.nickel_out && dif.dime_out) both = 1'b1;
            dif.hopper_ack = (mode == 1) && (w == 0 || w == 2);
            tick();
            w++;
        end
        dif.hopper_ack = 1'b0;
        check_eq({tag, "_width"}, w, 4);
        check_eq({tag, "_excl"}, 32'(both), 0);
        if (mode == 0) begin
            dif.hopper_ack = 1'b1;
            tick();
            dif.hopper_ack = 1'b0;
        end
        check_eq({tag, "_rem"}, 32'(dif.remaining), exp_rem);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!dif.done && k < 20) begin
            tick();
            k++;
        end
        check_eq({tag, "_done"}, 32'(dif.done), 1);
        check_eq({tag, "_busy_at_done"}, 32'(dif.busy), 0);
        tick();
        check_eq({tag, "_done_1cyc"}, 32'(dif.done), 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        tick();
        tick();
        check_eq({tag, "_outs"},
                 32'({dif.nickel_out, dif.dime_out, dif.busy, dif.done, dif.fault}), 0);
        check_eq({tag, "_rem"}, 32'(dif.remaining), 0);
        rst = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        total          = 0;
        bad            = 0;
        rst            = 1'b0;
        dif.start      = 1'b0;
        dif.amount     = '0;
        dif.dime_empty = 1'b0;
        dif.hopper_ack = 1'b0;
        tick();
        do_reset("reset");

        // amount 7: dime, dime, dime, nickel
        request(7);
        check_eq("a7_busy", 32'(dif.busy), 1);
        check_eq("a7_rem0", 32'(dif.remaining), 7);
        serve_coin("a7_c1", 1'b1, 5, 0);
        serve_coin("a7_c2", 1'b1, 3, 0);
        serve_coin("a7_c3", 1'b1, 1, 0);
        serve_coin("a7_c4", 1'b0, 0, 0);
        wait_done("a7");

        // amount 0: one busy cycle, done next, no coin
        request(0);
        check_eq("a0_busy", 32'(dif.busy), 1);
        check_eq("a0_done_early", 32'(dif.done), 0);
        tick();
        check_eq("a0_done", 32'(dif.done), 1);
        check_eq("a0_busy_off", 32'(dif.busy), 0);
        check_eq("a0_coins", 32'({dif.nickel_out, dif.dime_out}), 0);
        tick();
        check_eq("a0_done_off", 32'(dif.done), 0);

        // amount 6: dime hopper empties after the first coin
        request(6);
        serve_coin("a6_c1", 1'b1, 4, 0);
        dif.dime_empty = 1'b1;
        serve_coin("a6_c2", 1'b0, 3, 0);
        serve_coin("a6_c3", 1'b0, 2, 0);
        serve_coin("a6_c4", 1'b0, 1, 0);
        serve_coin("a6_c5", 1'b0, 0, 0);
        wait_done("a6");
        dif.dime_empty = 1'b0;

        // amount 4: double ack on first coin, second start while busy
        request(4);
        dif.amount = 5'd9;
        dif.start  = 1'b1;
        tick();
        dif.start  = 1'b0;
        serve_coin("a4d_c1", 1'b1, 2, 1);
        serve_coin("a4d_c2", 1'b1, 0, 0);
        wait_done("a4d");
        tick();
        tick();
        check_eq("a4d_idle_busy", 32'(dif.busy), 0);
        check_eq("a4d_idle_rem", 32'(dif.remaining), 0);

        // amount 3: no ack -> fault 20 cycles after pulse start
        request(3);
        serve_coin("a3_c1", 1'b1, 3, 2);
        n = 0;
        while (!dif.fault && n < 40) begin
            tick();
            n++;
        end
        check_eq("a3_fault_latency", n, 16);
        check_eq("a3_fault", 32'(dif.fault), 1);
        check_eq("a3_busy", 32'(dif.busy), 0);
        check_eq("a3_rem", 32'(dif.remaining), 3);
        request(5);
        tick();
        tick();
        check_eq("a3_fault_hold", 32'(dif.fault), 1);
        check_eq("a3_start_ignored_busy", 32'(dif.busy), 0);
        check_eq("a3_start_ignored_rem", 32'(dif.remaining), 3);
        check_eq("a3_no_coin", 32'({dif.nickel_out, dif.dime_out}), 0);
        do_reset("a3_clear");

        // amount 4: reset in the middle of the second pulse
        request(4);
        serve_coin("a4r_c1", 1'b1, 2, 0);
        n = 0;
        while (!dif.dime_out && n < 50) begin
            tick();
            n++;
        end
        check_eq("a4r_c2_start", 32'(dif.dime_out), 1);
        tick();
        #2 rst = 1'b0;
        #1;
        check_eq("a4r_async_outs", 32'({dif.nickel_out, dif.dime_out, dif.busy}), 0);
        check_eq("a4r_async_rem", 32'(dif.remaining), 0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        check_eq("a4r_idle_busy", 32'(dif.busy), 0);
        request(1);
        serve_coin("a4r_after", 1'b0, 0, 0);
        wait_done("a4r_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL take these parameters, each listed as name, default, meaning:
- PULSE_CYCLES, 10: coin solenoid pulse width in clk cycles.
- GAP_CYCLES, 5: idle cycles between consecutive coins.
- ACK_TIMEOUT, 50: cycles from pulse start to wait for hopper_ack before fault.
REQ-002 The block SHALL have these ports, each listed as name, direction, width, meaning:
- clk, in, 1: single clock (100 Hz system clock).
- rst, in, 1: reset, asynchronous, active-low.
- start, in, 1: request payout of amount.
- amount, in, 5: payout value in nickel units (0..31; dime = 2).
- dime_empty, in, 1: dime hopper empty.
- hopper_ack, in, 1: coin-exit sensor, one pulse per coin dispensed.
- nickel_out, out, 1: nickel solenoid drive.
- dime_out, out, 1: dime solenoid drive.
- busy, out, 1: payout in progress.
- done, out, 1: one-cycle payout-complete pulse.
- fault, out, 1: sticky ack-timeout fault.
- remaining, out, 5: nickel units still owed.

Function
REQ-003 FSM states SHALL be IDLE, SELECT, PULSE, WAIT_ACK, GAP, DONE, FAULT.
REQ-004 In IDLE, start=1 SHALL latch amount into remaining and enter SELECT; busy SHALL be 1 from the next cycle.
REQ-005 start SHALL be ignored in every state except IDLE.
REQ-006 SELECT, remaining=0: the FSM SHALL go to DONE with no coin driven.
REQ-007 SELECT, remaining>=2 and dime_empty=0: the FSM SHALL choose a dime; otherwise it SHALL choose a nickel. The choice is made once per coin and held until that coin completes.
REQ-008 PULSE SHALL drive the chosen output (dime_out or nickel_out) high for exactly PULSE_CYCLES cycles, then enter WAIT_ACK; both outputs SHALL never be high together.
REQ-009 hopper_ack SHALL be sampled only in PULSE and WAIT_ACK; the first ack per coin SHALL decrement remaining by 2 (dime) or 1 (nickel), exactly once.
REQ-010 Additional acks for the same coin, and acks in any other state, SHALL be ignored.
REQ-011 If an ack occurs during PULSE, the pulse SHALL still complete; WAIT_ACK SHALL then exit to GAP on its first cycle.
REQ-012 WAIT_ACK SHALL exit to GAP once the ack has been received.
REQ-013 If no ack is received within ACK_TIMEOUT cycles counted from the first PULSE cycle, the FSM SHALL enter FAULT and leave remaining unchanged.
REQ-014 GAP SHALL last GAP_CYCLES cycles, then return to SELECT.
REQ-015 dime_empty SHALL be re-evaluated on every SELECT visit, so the FSM falls back to nickels mid-payout.
REQ-016 DONE SHALL last one cycle with done=1 and busy=0, then go to IDLE.
REQ-017 FAULT SHALL hold fault=1 and busy=0, drive no coin, ignore start, and exit only on reset.
REQ-018 remaining SHALL never underflow; a nickel SHALL be chosen whenever remaining=1.

Reset
REQ-019 While rst=0: the state SHALL be IDLE; remaining, nickel_out, dime_out, busy, done, fault SHALL all be 0; all counters SHALL be 0.
REQ-020 Reset asserted mid-pulse SHALL drop the coin output asynchronously, and the owed value SHALL be lost.

Structure
REQ-021 The state typedef (dispense_state_t) and coin typedef (coin_t: NICKEL, DIME) SHALL live in the shared package vend_pkg, alongside the existing vending typedefs.
REQ-022 A single down-counter sub-module, cycle_timer (load, value, expired), SHALL be reused for the pulse, gap and timeout timing.

Verification (bench parameters PULSE_CYCLES=4, GAP_CYCLES=2, ACK_TIMEOUT=20)
REQ-023 amount=7, dime_empty=0, ack 1 cycle after each pulse ends -> dime, dime, dime, nickel pulses in that order; remaining steps 7,5,3,1,0; then one done pulse.
REQ-024 amount=0 -> busy high for 1 cycle, done 2 cycles after start, no coin output.
REQ-025 amount=6, dime_empty rises after the first ack -> one dime then four nickels; done pulses.
REQ-026 amount=3, no ack on the first coin -> FAULT entered 20 cycles after pulse start; fault=1; remaining=3; a subsequent start is ignored.
REQ-027 amount=4 with a double ack on the first coin, plus a start pulse while busy -> remaining decrements by 2 only; the second request is ignored.
REQ-028 rst low during the second PULSE of amount=4 -> outputs 0 immediately; IDLE after release.
